lifo_stack_dp: RTL and testbench
================================

Name: lifo_stack_dp

Overview:
- Data-side LIFO stack: accepts push transactions and serves pop transactions, both over valid/ready handshakes.
- Keeps its own stack pointer/occupancy and a registered top-of-stack (TOS) entry; entries below TOS live in a register-file array.
- Sits between a producer issuing push requests and a consumer draining pops; exports occupancy and sticky misuse flags to control/status logic.

Parameters:
- DEPTH, 16, total entries including TOS register; power of two, >= 2.
- DATA_W, 8, entry width in bits.
- PTR_W, $clog2(DEPTH), array index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- push_valid  in  1  producer has push_data.
- push_ready  out  1  stack can accept a push; equals !full.
- push_data  in  DATA_W  data to push.
- pop_valid  out  1  TOS valid; equals !empty.
- pop_ready  in  1  consumer takes TOS.
- pop_data  out  DATA_W  current TOS, driven straight from the TOS register.
- count  out  PTR_W+1  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf_err  out  1  sticky: push attempted while full.
- unf_err  out  1  sticky: pop attempted while empty.
- clr_err  in  1  clears both sticky flags.

Behaviour:
- Reset (async):
  - count=0, TOS=0, ovf_err=0, unf_err=0.
  - Hence full=0, empty=1, push_ready=1, pop_valid=0.
  - Array contents are don't-care.
- Handshake signals:
  - push_fire = push_valid & push_ready.
  - pop_fire = pop_valid & pop_ready.
  - No combinational path from any input to push_ready/pop_valid.
- Push only (count=c):
  - c>0: array[c-1] <= TOS.
  - TOS <= push_data; count <= c+1.
- Pop only (count=c):
  - c>=2: TOS <= array[c-2] (asynchronous array read).
  - c==1: TOS holds its old value (don't-care).
  - count <= c-1.
- Push and pop fire in the same cycle (requires 0<c<DEPTH): replace. TOS <= push_data, count unchanged, array untouched. pop_data in that cycle is the old TOS.
- Full: push_ready=0, so no push fires even with a simultaneous pop; the pop alone proceeds.
- Empty: pop_valid=0, so no pop fires; a simultaneous push proceeds.
- Latency: a pushed value appears on pop_data the cycle after push_fire. Push then immediate pop returns that value.
- Pointer arithmetic: count is PTR_W+1 bits and never wraps; the handshake gating makes over/underflow unreachable.
- Error flags:
  - ovf_err sets on push_valid & full; unf_err sets on pop_ready & empty.
  - clr_err clears both next cycle; a set in the same cycle wins over clear.
- Reset mid-traffic: in-flight handshakes are dropped and the state returns to reset values immediately.

Optional Feature:
- Macro LIFO_FLUSH_EN.
- Defined:
  - Adds input flush (1 bit, synchronous).
  - flush=1 sets count <= 0 next cycle, ignoring any push/pop that cycle; the fires are discarded and error flags are not set by them.
  - pop_valid drops the cycle after flush. TOS and array are untouched.
- Undefined: no flush port; behaviour as above.

Decomposition:
- Package lifo_pkg: default DEPTH/DATA_W constants and a 2-bit op encoding (OP_IDLE, OP_PUSH, OP_POP, OP_REPL) derived from {push_fire, pop_fire}.
- One sub-module, lifo_regfile: DEPTH-1 entries x DATA_W, single synchronous write port, single asynchronous read port, no reset.
- lifo_stack_dp holds count, TOS, flags and handshake logic.

Test Plan:
- Reset → count=0, empty=1, full=0, push_ready=1, pop_valid=0, ovf_err=unf_err=0.
- Push 0x11, 0x22, 0x33 back-to-back, then pop 3 → pop_data sequence 0x33, 0x22, 0x11; count 3→0; empty=1 after the last pop.
- Fill with 16 pushes of 0x00..0x0F → full=1, push_ready=0, pop_data=0x0F. A 17th push_valid → no state change, ovf_err=1. Pop 16 → 0x0F..0x00.
- With count=2 (TOS=0xA5), push 0x5A and pop in the same cycle → pop returns 0xA5, count stays 2, next pop_data=0x5A.
- Empty stack, pop_ready=1 → unf_err=1 and stays 1. clr_err with pop_ready=1 still asserted → flag stays 1 (set wins). Drop pop_ready, pulse clr_err → flag 0 next cycle.
- With count=5, assert rst asynchronously mid-push → count=0 and pop_valid=0 before the next clk edge. With LIFO_FLUSH_EN: flush at count=7 → count=0 next cycle.

Source files
------------

// File: rtl/lifo_pkg.sv
// lifo_pkg: default stack geometry and the per-cycle operation encoding {push_fire, pop_fire}
package lifo_pkg;
    localparam int LIFO_DEPTH  = 16;
    localparam int LIFO_DATA_W = 8;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_REPL = 2'b11
    } op_e;
endpackage

// File: rtl/lifo_stack_dp_if.sv
// lifo_stack_dp_if: push and pop valid/ready channels; master = producer/consumer, slave = stack
interface lifo_stack_dp_if
    import lifo_pkg::*;
#(
    parameter int DATA_W = LIFO_DATA_W
);
    logic              push_valid;
    logic              push_ready;
    logic [DATA_W-1:0] push_data;
    logic              pop_valid;
    logic              pop_ready;
    logic [DATA_W-1:0] pop_data;

    modport master (
        output push_valid, push_data, pop_ready,
        input  push_ready, pop_valid, pop_data
    );

    modport slave (
        input  push_valid, push_data, pop_ready,
        output push_ready, pop_valid, pop_data
    );
endinterface

// File: rtl/lifo_regfile.sv
// lifo_regfile: storage below TOS; one synchronous write port, one asynchronous read port, no reset
module lifo_regfile #(
    parameter int N   = 15,
    parameter int W   = 8,
    parameter int A_W = 4
) (
    input  logic           clk,
    input  logic           wr_en,
    input  logic [A_W-1:0] wr_addr,
    input  logic [W-1:0]   wr_data,
    input  logic [A_W-1:0] rd_addr,
    output logic [W-1:0]   rd_data
);
    logic [W-1:0] mem [N];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    // addresses past the last entry occur only when the read is unused
    assign rd_data = 32'(rd_addr) < N ? mem[rd_addr] : '0;
endmodule

// File: rtl/lifo_stack_dp.sv
// lifo_stack_dp: valid/ready LIFO with a registered TOS over a register file.
// Optional macro LIFO_FLUSH_EN adds a synchronous flush input.
module lifo_stack_dp
    import lifo_pkg::*;
#(
    parameter int DEPTH  = LIFO_DEPTH,
    parameter int DATA_W = LIFO_DATA_W,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    lifo_stack_dp_if.slave bus,
    output logic [PTR_W:0] count,
    output logic           full,
    output logic           empty,
    output logic           ovf_err,
    output logic           unf_err,
`ifdef LIFO_FLUSH_EN
    input  logic           flush,
`endif
    input  logic           clr_err
);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE     = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO     = (PTR_W+1)'(2);

    logic [DATA_W-1:0] tos, tos_nxt, rd_data;
    logic [PTR_W:0]    count_nxt;
    logic [PTR_W-1:0]  wr_addr, rd_addr;
    logic              push_fire, pop_fire, fl, wr_en, ovf_nxt, unf_nxt;
    op_e               op;

`ifdef LIFO_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif

    assign full           = count == CNT_MAX;
    assign empty          = count == '0;
    assign bus.push_ready = !full;
    assign bus.pop_valid  = !empty;
    assign bus.pop_data   = tos;
    assign push_fire      = bus.push_valid && !full;
    assign pop_fire       = bus.pop_ready && !empty;
    assign op             = op_e'({push_fire, pop_fire});
    assign wr_addr        = PTR_W'(count - ONE);
    assign rd_addr        = PTR_W'(count - TWO);

    always_comb begin
        tos_nxt   = tos;
        count_nxt = count;
        wr_en     = 1'b0;
        if (fl) begin
            count_nxt = '0;
        end else if (op == OP_PUSH) begin
            wr_en     = !empty;
            tos_nxt   = bus.push_data;
            count_nxt = count + ONE;
        end else if (op == OP_POP) begin
            tos_nxt   = count >= TWO ? rd_data : tos;
            count_nxt = count - ONE;
        end else if (op == OP_REPL) begin
            tos_nxt   = bus.push_data;
        end
    end

    // a new misuse in the same cycle as clr_err keeps the flag set
    assign ovf_nxt = (bus.push_valid && full && !fl) || (ovf_err && !clr_err);
    assign unf_nxt = (bus.pop_ready && empty && !fl) || (unf_err && !clr_err);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            count   <= '0;
            tos     <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            count   <= count_nxt;
            tos     <= tos_nxt;
            ovf_err <= ovf_nxt;
            unf_err <= unf_nxt;
        end

    lifo_regfile #(
        .N   (DEPTH - 1),
        .W   (DATA_W),
        .A_W (PTR_W)
    ) u_rf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (tos),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );
endmodule

// File: tb/tb_lifo_stack_dp.sv
// tb_lifo_stack_dp: directed plus random traffic checked against a queue model of the stack
module tb_lifo_stack_dp;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] count;
    logic       full, empty, ovf_err, unf_err, clr_err;
`ifdef LIFO_FLUSH_EN
    logic       flush;
`endif

    lifo_stack_dp_if #(.DATA_W(8)) bus ();

    lifo_stack_dp dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .ovf_err (ovf_err),
        .unf_err (unf_err),
`ifdef LIFO_FLUSH_EN
        .flush   (flush),
`endif
        .clr_err (clr_err)
    );

    always #5 clk = ~clk;

    int       checks = 0;
    int       errors = 0;
    bit       chk_en = 1'b0;
    bit [7:0] q[$];
    bit       ovf_m = 1'b0;
    bit       unf_m = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_en) begin
            chk("count", int'(count), q.size());
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("push_ready", int'(bus.push_ready), int'(q.size() != DEPTH));
            chk("pop_valid", int'(bus.pop_valid), int'(q.size() != 0));
            chk("ovf_err", int'(ovf_err), int'(ovf_m));
            chk("unf_err", int'(unf_err), int'(unf_m));
            if (q.size() > 0) chk("pop_data", int'(bus.pop_data), int'(q[$]));
        end

    task automatic cyc(input bit pv, input bit [7:0] pd, input bit pr, input bit clr, input bit fl);
        int n;
        bit pf, of;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.pop_ready  = pr;
        clr_err        = clr;
`ifdef LIFO_FLUSH_EN
        flush          = fl;
`endif
        @(posedge clk);
        n     = q.size();
        ovf_m = (!fl && pv && n == DEPTH) || (ovf_m && !clr);
        unf_m = (!fl && pr && n == 0) || (unf_m && !clr);
        if (fl) q.delete();
        else begin
            pf = pv && n < DEPTH;
            of = pr && n > 0;
            if (pf && of) q[n-1] = pd;
            else if (pf) q.push_back(pd);
            else if (of) void'(q.pop_back());
        end
        @(negedge clk);
    endtask

    initial begin
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.pop_ready  = 1'b0;
        clr_err        = 1'b0;
`ifdef LIFO_FLUSH_EN
        flush          = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_push_ready", int'(bus.push_ready), 1);
        chk("rst_pop_valid", int'(bus.pop_valid), 0);
        chk("rst_ovf", int'(ovf_err), 0);
        chk("rst_unf", int'(unf_err), 0);
        chk("rst_tos", int'(bus.pop_data), 0);
        chk_en = 1'b1;

        cyc(1, 8'h11, 0, 0, 0);
        cyc(1, 8'h22, 0, 0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        chk("lit_count3", int'(count), 3);
        chk("lit_pop0", int'(bus.pop_data), 'h33);
        cyc(0, 0, 1, 0, 0);
        chk("lit_pop1", int'(bus.pop_data), 'h22);
        cyc(0, 0, 1, 0, 0);
        chk("lit_pop2", int'(bus.pop_data), 'h11);
        cyc(0, 0, 1, 0, 0);
        chk("lit_empty", int'(empty), 1);

        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0, 0);
        chk("lit_full", int'(full), 1);
        chk("lit_full_ready", int'(bus.push_ready), 0);
        chk("lit_full_tos", int'(bus.pop_data), 'h0F);
        cyc(1, 8'h99, 0, 0, 0);
        chk("lit_ovf", int'(ovf_err), 1);
        chk("lit_ovf_count", int'(count), 16);
        chk("lit_ovf_tos", int'(bus.pop_data), 'h0F);
        cyc(1, 8'h98, 1, 0, 0);
        chk("lit_full_pop_only", int'(count), 15);
        chk("lit_full_pop_tos", int'(bus.pop_data), 'h0E);
        for (int i = 14; i >= 0; i--) begin
            chk("lit_drain", int'(bus.pop_data), i);
            cyc(0, 0, 1, 0, 0);
        end
        cyc(0, 0, 0, 1, 0);
        chk("lit_ovf_clr", int'(ovf_err), 0);

        cyc(1, 8'h01, 0, 0, 0);
        cyc(1, 8'hA5, 0, 0, 0);
        chk("lit_repl_pre", int'(bus.pop_data), 'hA5);
        cyc(1, 8'h5A, 1, 0, 0);
        chk("lit_repl_count", int'(count), 2);
        chk("lit_repl_tos", int'(bus.pop_data), 'h5A);
        cyc(0, 0, 1, 0, 0);
        chk("lit_repl_below", int'(bus.pop_data), 'h01);
        cyc(0, 0, 1, 0, 0);

        cyc(0, 0, 1, 0, 0);
        chk("lit_unf", int'(unf_err), 1);
        cyc(0, 0, 1, 0, 0);
        chk("lit_unf_sticky", int'(unf_err), 1);
        cyc(0, 0, 1, 1, 0);
        chk("lit_unf_setwins", int'(unf_err), 1);
        cyc(0, 0, 0, 1, 0);
        chk("lit_unf_clr", int'(unf_err), 0);
        cyc(1, 8'h3C, 0, 0, 0);
        chk("lit_push_empty", int'(bus.pop_data), 'h3C);

`ifdef LIFO_FLUSH_EN
        for (int i = 0; i < 6; i++) cyc(1, 8'(i + 'h40), 0, 0, 0);
        chk("lit_pre_flush", int'(count), 7);
        cyc(1, 8'h77, 1, 0, 1);
        chk("lit_flush_count", int'(count), 0);
        chk("lit_flush_valid", int'(bus.pop_valid), 0);
        cyc(0, 0, 1, 0, 1);
        chk("lit_flush_unf", int'(unf_err), 0);
`endif

        for (int ph = 0; ph < 3; ph++) begin
            int pp;
            pp = (ph == 0) ? 75 : (ph == 1) ? 25 : 50;
            for (int i = 0; i < 600; i++)
                cyc($urandom_range(99) < pp, 8'($urandom), $urandom_range(99) >= pp,
                    $urandom_range(99) < 3,
`ifdef LIFO_FLUSH_EN
                    $urandom_range(99) < 2);
`else
                    1'b0);
`endif
        end

        while (q.size() > 0) cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 8'(i + 'h60), 0, 0, 0);
        chk("lit_pre_rst", int'(count), 5);
        bus.push_valid = 1'b1;
        bus.push_data  = 8'h77;
        chk_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("lit_arst_count", int'(count), 0);
        chk("lit_arst_valid", int'(bus.pop_valid), 0);
        chk("lit_arst_empty", int'(empty), 1);
        q.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.push_valid = 1'b0;
        chk_en = 1'b1;
        cyc(1, 8'h81, 0, 0, 0);
        chk("lit_post_rst", int'(bus.pop_data), 'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
